c3aibadapt_sr_load_shift_ctl: RTL and testbench

- Downstream consumer of the adapter async capture bus.
- Takes the captured parallel status word (capt_data) on request and shifts it out LSB-first onto the serial shift-register chain.
- At the same time it shifts the upstream chain bit (sr_in) in and presents it as a parallel word.
- Drives unload back to the capture bus so that no new sample is taken while a frame is in flight. After the frame it enforces a quiet gap so the capture bus can re-qualify fresh data.

---
 rtl/c3aibadapt_sr_load_shift_ctl_if.sv | 26 ++
 rtl/c3aibadapt_sr_load_shift_ctl.sv | 113 +++++++++++
 tb/tb_c3aibadapt_sr_load_shift_ctl.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/c3aibadapt_sr_load_shift_ctl_if.sv
// Bus between the capture-side requester and the serial load/shift controller.
interface c3aibadapt_sr_load_shift_ctl_if #(
    parameter int unsigned DWIDTH = 16
);
    logic              start;
    logic [DWIDTH-1:0] capt_data;
    logic              sr_in;
    logic              unload;
    logic              sr_load;
    logic              sr_out;
    logic [DWIDTH-1:0] par_out;
    logic              busy;
    logic              done;

    // Requester side: issues frames and feeds the chain input.
    modport master (
        output start, capt_data, sr_in,
        input  unload, sr_load, sr_out, par_out, busy, done
    );

    // Controller side.
    modport slave (
        input  start, capt_data, sr_in,
        output unload, sr_load, sr_out, par_out, busy, done
    );
endinterface

// File: rtl/c3aibadapt_sr_load_shift_ctl.sv
// Loads the captured status word, shifts it out LSB-first on sr_out while
// assembling sr_in into par_out, then holds unload low for a quiet gap.
module c3aibadapt_sr_load_shift_ctl #(
    parameter int unsigned DWIDTH    = 16,
    parameter int unsigned GAP_CYC   = 3,
    parameter logic        RESET_VAL = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    c3aibadapt_sr_load_shift_ctl_if.slave bus
);
    localparam int unsigned BW = $clog2(DWIDTH);
    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    state_t            state_q, state_d;
    logic [DWIDTH-1:0] shift_q, shift_d;
    logic [DWIDTH-1:0] par_q, par_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              pend_q, pend_d;
    logic              sr_out_q, sr_out_d;
    logic              unload_q, unload_d;
    logic              sr_load_q, sr_load_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state, datapath and registered-output decode.
    // Outputs are decoded from the next state so every output is a flop.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        par_d    = par_q;
        bit_d    = bit_q;
        gap_d    = gap_q;
        pend_d   = pend_q;
        sr_out_d = sr_out_q;
        case (state_q)
            IDLE: begin
                if (bus.start || pend_q) begin
                    state_d = LOAD;
                    pend_d  = 1'b0;
                end
            end
            LOAD: begin
                if (bus.start) pend_d = 1'b1;
                shift_d  = bus.capt_data;
                bit_d    = BW'(DWIDTH - 1);
                sr_out_d = bus.capt_data[0];
                state_d  = SHIFT;
            end
            SHIFT: begin
                if (bus.start) pend_d = 1'b1;
                shift_d = {bus.sr_in, shift_q[DWIDTH-1:1]};
                if (bit_q == '0) begin
                    state_d = GAP;
                    gap_d   = GW'(GAP_CYC - 1);
                    par_d   = {bus.sr_in, shift_q[DWIDTH-1:1]};
                end else begin
                    bit_d    = bit_q - 1'b1;
                    sr_out_d = shift_q[1];
                end
            end
            GAP: begin
                if (bus.start) pend_d = 1'b1;
                if (gap_q == '0) state_d = IDLE;
                else             gap_d   = gap_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
        unload_d  = (state_d == LOAD) || (state_d == SHIFT);
        sr_load_d = (state_d == LOAD);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == GAP) && (gap_d == '0);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            par_q     <= '0;
            bit_q     <= '0;
            gap_q     <= '0;
            pend_q    <= 1'b0;
            sr_out_q  <= RESET_VAL;
            unload_q  <= 1'b0;
            sr_load_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            bit_q     <= bit_d;
            gap_q     <= gap_d;
            pend_q    <= pend_d;
            sr_out_q  <= sr_out_d;
            unload_q  <= unload_d;
            sr_load_q <= sr_load_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.unload  = unload_q;
    assign bus.sr_load = sr_load_q;
    assign bus.sr_out  = sr_out_q;
    assign bus.par_out = par_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_c3aibadapt_sr_load_shift_ctl.sv
// Directed bench for the serial load/shift controller (DWIDTH=8, GAP_CYC=3).
module tb_c3aibadapt_sr_load_shift_ctl;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    logic [7:0] prev_par;

    c3aibadapt_sr_load_shift_ctl_if #(.DWIDTH(8)) bus ();

    c3aibadapt_sr_load_shift_ctl #(
        .DWIDTH   (8),
        .GAP_CYC  (3),
        .RESET_VAL(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk1({tag, "_busy"}, bus.busy, 1'b0);
        chk1({tag, "_unload"}, bus.unload, 1'b0);
        chk1({tag, "_sr_load"}, bus.sr_load, 1'b0);
        chk1({tag, "_done"}, bus.done, 1'b0);
    endtask

    // Entered in the LOAD cycle; returns in the IDLE cycle after done.
    task automatic check_frame(input logic [7:0] word, input logic [7:0] sin,
                               input logic [7:0] smask, input bit hold);
        bus.capt_data = word;
        bus.start     = hold;
        bus.sr_in     = 1'b0;
        chk1("load_sr_load", bus.sr_load, 1'b1);
        chk1("load_unload", bus.unload, 1'b1);
        chk1("load_busy", bus.busy, 1'b1);
        chk1("load_done", bus.done, 1'b0);
        chk8("load_par_hold", bus.par_out, prev_par);
        step();
        for (int i = 0; i < 8; i++) begin
            chk1("shift_sr_out", bus.sr_out, word[i]);
            chk1("shift_unload", bus.unload, 1'b1);
            chk1("shift_sr_load", bus.sr_load, 1'b0);
            chk1("shift_busy", bus.busy, 1'b1);
            if (i == 3) bus.capt_data = ~word;
            bus.sr_in = sin[i];
            bus.start = hold | smask[i];
            step();
        end
        bus.start = hold;
        bus.sr_in = 1'b0;
        for (int g = 0; g < 3; g++) begin
            chk1("gap_unload", bus.unload, 1'b0);
            chk1("gap_busy", bus.busy, 1'b1);
            chk1("gap_done", bus.done, (g == 2));
            chk8("gap_par_out", bus.par_out, sin);
            chk1("gap_sr_out", bus.sr_out, word[7]);
            step();
        end
        prev_par = sin;
        chk_idle("post_frame");
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        prev_par      = 8'h00;
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.capt_data = 8'h00;
        bus.sr_in     = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;

        // Quiet after reset release.
        for (int c = 0; c < 20; c++) begin
            chk_idle("rst_idle");
            chk1("rst_sr_out", bus.sr_out, 1'b1);
            chk8("rst_par_out", bus.par_out, 8'h00);
            step();
        end

        // Single pulse, A5, sr_in low.
        bus.start = 1'b1;
        step();
        check_frame(8'hA5, 8'h00, 8'h00, 1'b0);
        step();

        // Same word, sr_in = 0,1,1,0,1,1,1,1 -> par_out F6.
        bus.start = 1'b1;
        step();
        check_frame(8'hA5, 8'hF6, 8'h00, 1'b0);
        step();

        // start held high: one IDLE cycle between done and next sr_load.
        bus.start = 1'b1;
        step();
        check_frame(8'h3C, 8'h81, 8'h00, 1'b1);
        step();
        check_frame(8'h5A, 8'h42, 8'h00, 1'b0);
        step();
        chk_idle("hold_end");

        // Two pulses during SHIFT: exactly one extra frame.
        bus.start = 1'b1;
        step();
        check_frame(8'hC3, 8'h18, 8'b0010_0100, 1'b0);
        step();
        check_frame(8'h96, 8'h7E, 8'h00, 1'b0);
        step();
        for (int c = 0; c < 6; c++) begin
            chk_idle("no_third");
            step();
        end

        // Reset at SHIFT cycle 3, with a request pending.
        bus.capt_data = 8'hE7;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            bus.start = (i == 1);
            step();
        end
        bus.start = 1'b0;
        chk1("pre_rst_unload", bus.unload, 1'b1);
        rst_n = 1'b0;
        #1;
        chk_idle("midrst");
        chk1("midrst_sr_out", bus.sr_out, 1'b1);
        chk8("midrst_par_out", bus.par_out, 8'h00);
        step();
        rst_n = 1'b1;
        prev_par = 8'h00;
        for (int c = 0; c < 5; c++) begin
            chk_idle("pend_lost");
            step();
        end
        bus.start = 1'b1;
        step();
        check_frame(8'h69, 8'hB2, 8'h00, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
